instruction_fetch: RTL and testbench

//  Fetch stage upstream of cpu: holds PC, instruction memory, next-PC select.

---
 rtl/instruction_fetch.sv | 107 ++++++++++
 tb/tb_instruction_fetch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, instruction memory with a bench load port, next-PC mux,
// IDLE/RUN/FAULT control and a retired-instruction counter.
module instruction_fetch #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013,
    localparam int         ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic [1:0]        pc_source,
    input  logic [31:0]       imm,
    input  logic [31:0]       rs1_data,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4,
    output logic [31:0]       instruction,
    output logic              inst_valid,
    output logic              fault,
    output logic [31:0]       retired,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] imem [IMEM_DEPTH];

    logic [31:0] jalr_sum;
    logic [31:0] next_pc;
    logic        next_bad;
    logic        advance;

    always_comb begin
        jalr_sum = rs1_data + imm;
        case (pc_source)
            2'b01:   next_pc = pc_q + imm;
            2'b10:   next_pc = jalr_sum & 32'hFFFF_FFFE;
            default: next_pc = pc_q + 32'd4;
        endcase
        next_bad = (next_pc[1:0] != 2'b00) || (next_pc[31:2] >= 30'(IMEM_DEPTH));
    end

    // Stalled cycles skip the fault check entirely, so a bad target under stall is harmless.
    assign advance = (state_q == S_RUN) && !stall && !next_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (!stall && next_bad) state_d = S_FAULT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_d      = advance ? next_pc : pc_q;
        retired_d = advance ? retired_q + 32'd1 : retired_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            retired_q <= 32'd0;
        end else begin
            pc_q      <= pc_d;
            retired_q <= retired_d;
        end
    end

    // Memory has no reset so a program survives rst; it is writable only while IDLE.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && load_en) begin
            imem[load_addr] <= load_data;
        end
    end

    always_comb begin
        inst_valid  = (state_q == S_RUN);
        fault       = (state_q == S_FAULT);
        instruction = inst_valid ? imem[pc_q[ADDR_W+1:2]] : NOP_INST;
        pc          = pc_q;
        pc_plus4    = pc_q + 32'd4;
        retired     = retired_q;
        dbg_state   = state_q;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a 256-word instance for the main flow and a
// 16-word instance for the top-of-memory boundary, checked through one expected queue.
module tb_instruction_fetch;

    localparam int          W   = 99;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0  = 32'h0050_0093;
    localparam logic [31:0] I1  = 32'h00A0_0113;
    localparam logic [31:0] I2  = 32'h0020_81B3;
    localparam logic [31:0] I4  = 32'h2222_2222;
    localparam logic [31:0] I5  = 32'h3333_3333;
    localparam logic [31:0] I6  = 32'h4444_4444;
    localparam logic [31:0] IB  = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;
    logic        start_a, start_b;
    logic        stall;
    logic [1:0]  pc_source;
    logic [31:0] imm, rs1_data;
    logic        load_en, load_en_b;
    logic [7:0]  load_addr;
    logic [31:0] load_data;

    logic [31:0] pc_a, pc_plus4_a, instruction_a, retired_a;
    logic        inst_valid_a, fault_a;
    logic [1:0]  dbg_state_a;
    logic [31:0] pc_b, pc_plus4_b, instruction_b, retired_b;
    logic        inst_valid_b, fault_b;
    logic [1:0]  dbg_state_b;

    // Expected record: {sel, pc, instruction, inst_valid, fault, retired}; sel=1 picks the 16-word DUT.
    logic [W-1:0] exp_q[$];
    int n_vectors;
    int n_miscompares;

    instruction_fetch #(.IMEM_DEPTH(256)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stall(stall), .pc_source(pc_source),
        .imm(imm), .rs1_data(rs1_data), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .pc(pc_a), .pc_plus4(pc_plus4_a), .instruction(instruction_a),
        .inst_valid(inst_valid_a), .fault(fault_a), .retired(retired_a), .dbg_state(dbg_state_a)
    );

    instruction_fetch #(.IMEM_DEPTH(16)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stall(stall), .pc_source(pc_source),
        .imm(imm), .rs1_data(rs1_data), .load_en(load_en_b), .load_addr(load_addr[3:0]),
        .load_data(load_data), .pc(pc_b), .pc_plus4(pc_plus4_b), .instruction(instruction_b),
        .inst_valid(inst_valid_b), .fault(fault_b), .retired(retired_b), .dbg_state(dbg_state_b)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver tasks
    task automatic push_exp(input logic sel, input logic [31:0] e_pc, input logic [31:0] e_inst,
                            input logic e_v, input logic e_f, input logic [31:0] e_ret);
        exp_q.push_back({sel, e_pc, e_inst, e_v, e_f, e_ret});
    endtask

    task automatic step(input logic sel, input logic [31:0] e_pc, input logic [31:0] e_inst,
                        input logic e_v, input logic e_f, input logic [31:0] e_ret);
        @(posedge clk);
        #1;
        start_a   = 1'b0;
        start_b   = 1'b0;
        stall     = 1'b0;
        pc_source = 2'b00;
        imm       = 32'd0;
        rs1_data  = 32'd0;
        load_en   = 1'b0;
        load_en_b = 1'b0;
        push_exp(sel, e_pc, e_inst, e_v, e_f, e_ret);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        push_exp(1'b0, 32'd0, NOP, 1'b0, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [97:0]  act;
        logic [31:0]  act_p4;
        logic [1:0]   act_st, exp_st;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e[98]) begin
                act    = {pc_b, instruction_b, inst_valid_b, fault_b, retired_b};
                act_p4 = pc_plus4_b;
                act_st = dbg_state_b;
            end else begin
                act    = {pc_a, instruction_a, inst_valid_a, fault_a, retired_a};
                act_p4 = pc_plus4_a;
                act_st = dbg_state_a;
            end
            exp_st = e[33] ? 2'd1 : (e[32] ? 2'd2 : 2'd0);
            n_vectors++;
            if (act !== e[97:0] || act_p4 !== e[97:66] + 32'd4 || act_st !== exp_st) begin
                n_miscompares++;
                $display("FAIL vec%0d dut=%0d: got pc=%h inst=%h v=%b f=%b ret=%0d p4=%h st=%0d, expected pc=%h inst=%h v=%b f=%b ret=%0d p4=%h st=%0d",
                         n_vectors, e[98], act[97:66], act[65:34], act[33], act[32], act[31:0],
                         act_p4, act_st, e[97:66], e[65:34], e[33], e[32], e[31:0],
                         e[97:66] + 32'd4, exp_st);
            end
        end
    end

    // Stimulus
    initial begin
        logic [7:0]  l_addr [9];
        logic [31:0] l_data [9];
        l_addr = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd15};
        l_data = '{I0, I1, I2, 32'h1111_1111, I4, I5, I6, 32'h5555_5555, IB};
        n_vectors     = 0;
        n_miscompares = 0;
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; stall = 1'b0; pc_source = 2'b00;
        imm = 32'd0; rs1_data = 32'd0; load_en = 1'b0; load_en_b = 1'b0;
        load_addr = 8'd0; load_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Program load; the final write coincides with start.
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 32'd0, NOP, 1'b0, 1'b0, 32'd0);
            load_en = 1'b1; load_en_b = 1'b1;
            load_addr = l_addr[i]; load_data = l_data[i];
            if (i == 8) start_a = 1'b1;
        end

        step(1'b0, 32'h00, I0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 32'h04, I1, 1'b1, 1'b0, 32'd1);
        step(1'b0, 32'h08, I2, 1'b1, 1'b0, 32'd2);
        pc_source = 2'b01; imm = 32'hFFFF_FFF8;
        step(1'b0, 32'h00, I0, 1'b1, 1'b0, 32'd3);
        step(1'b0, 32'h04, I1, 1'b1, 1'b0, 32'd4);
        step(1'b0, 32'h08, I2, 1'b1, 1'b0, 32'd5);
        pc_source = 2'b01; imm = 32'h10;
        step(1'b0, 32'h18, I6, 1'b1, 1'b0, 32'd6);
        pc_source = 2'b10; rs1_data = 32'h11; imm = 32'd4;
        load_en = 1'b1; load_addr = 8'd1; load_data = 32'hFFFF_FFFF;
        step(1'b0, 32'h14, I5, 1'b1, 1'b0, 32'd7);
        pc_source = 2'b10; rs1_data = 32'h11; imm = 32'd0;
        step(1'b0, 32'h10, I4, 1'b1, 1'b0, 32'd8);
        pc_source = 2'b11;
        step(1'b0, 32'h14, I5, 1'b1, 1'b0, 32'd9);
        pc_source = 2'b01; imm = 32'hFFFF_FFF0;

        // Three stalled cycles with a target that would fault if evaluated.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h04, I1, 1'b1, 1'b0, 32'd10);
            stall = 1'b1; pc_source = 2'b01; imm = 32'h7FF0;
        end
        step(1'b0, 32'h04, I1, 1'b1, 1'b0, 32'd10);
        step(1'b0, 32'h08, I2, 1'b1, 1'b0, 32'd11);
        start_a = 1'b1; pc_source = 2'b10; rs1_data = 32'h12; imm = 32'd0;
        step(1'b0, 32'h08, NOP, 1'b0, 1'b1, 32'd11);
        start_a = 1'b1; load_en = 1'b1; load_addr = 8'd0; load_data = 32'hFFFF_FFFF;
        pc_source = 2'b01;
        step(1'b0, 32'h08, NOP, 1'b0, 1'b1, 32'd11);

        do_reset();
        step(1'b0, 32'h00, NOP, 1'b0, 1'b0, 32'd0);
        start_a = 1'b1;
        step(1'b0, 32'h00, I0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 32'h04, I1, 1'b1, 1'b0, 32'd1);
        step(1'b0, 32'h08, I2, 1'b1, 1'b0, 32'd2);

        do_reset();
        step(1'b0, 32'h00, NOP, 1'b0, 1'b0, 32'd0);
        start_a = 1'b1;
        step(1'b0, 32'h00, I0, 1'b1, 1'b0, 32'd0);
        start_a = 1'b1;
        step(1'b0, 32'h04, I1, 1'b1, 1'b0, 32'd1);

        // 16-word instance: last word is fetchable, falling off the end faults.
        do_reset();
        step(1'b1, 32'h00, NOP, 1'b0, 1'b0, 32'd0);
        start_b = 1'b1;
        step(1'b1, 32'h00, I0, 1'b1, 1'b0, 32'd0);
        pc_source = 2'b01; imm = 32'h3C;
        step(1'b1, 32'h3C, IB, 1'b1, 1'b0, 32'd1);
        step(1'b1, 32'h3C, NOP, 1'b0, 1'b1, 32'd1);
        step(1'b1, 32'h3C, NOP, 1'b0, 1'b1, 32'd1);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #200000;
        n_miscompares++;
        $display("FAIL timeout: run still active at %0t, expected completion", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $fatal(1, "timeout");
    end

endmodule
